// File: rtl/calc_pkg.sv
// Shared types and constants for the ALU result display:
// FSM encoding, datapath widths and 7-segment patterns.
package calc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int RES_W = 7;
    localparam int BCD_W = 12;
    localparam int DIG_W = 4;

    // Patterns are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [DIG_W-1:0] CODE_BLANK = 4'hF;

    function automatic logic [DIG_W-1:0] dd_adj(input logic [DIG_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Result-load and display bus between the ALU side and the
// display block.
interface alu_result_display_if;
    import calc_pkg::*;

    logic [RES_W-1:0] res;
    logic             load;
    logic             busy;
    logic             valid;
    logic [BCD_W-1:0] bcd;
    logic [6:0]       seg;
    logic [2:0]       an;

    modport master (
        output res, load,
        input  busy, valid, bcd, seg, an
    );

    modport slave (
        input  res, load,
        output busy, valid, bcd, seg, an
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern;
// codes 10-15 produce a blank digit.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [DIG_W-1:0] i_code,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// Converts a 7-bit ALU result to BCD by double-dabble and
// multiplexes the three digits onto a common 7-segment display.
module alu_result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 16
) (
    input logic                clk,
    input logic                rst,
    alu_result_display_if.slave bus
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_shift;
    logic             w_done;

    logic [RES_W-1:0] r_shreg;
    logic [BCD_W-1:0] r_scratch;
    logic [2:0]       r_cnt;
    logic             r_fin;
    logic             r_busy;
    logic             r_valid;
    logic [BCD_W-1:0] r_bcd;
    logic [BCD_W-1:0] w_adj;

    logic [REF_W-1:0] r_ref;
    logic [1:0]       r_dig;
    logic [2:0]       r_an;
    logic [6:0]       r_seg;
    logic [DIG_W-1:0] w_code;
    logic [2:0]       w_an;
    logic [6:0]       w_seg;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_shift  = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_accept = 1'b1;
                    w_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == 3'd6) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_adj = {dd_adj(r_scratch[11:8]),
                    dd_adj(r_scratch[7:4]),
                    dd_adj(r_scratch[3:0])};

    // Result publishes one cycle after DONE so busy spans 8 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_fin     <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_fin <= w_done;
            if (w_shift) begin
                {r_scratch, r_shreg} <= {w_adj, r_shreg} << 1;
                r_cnt <= r_cnt + 3'd1;
            end
            if (r_fin) begin
                r_bcd   <= r_scratch;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                r_busy <= 1'b1;
            end
            if (w_accept) begin
                r_shreg   <= bus.res;
                r_scratch <= '0;
                r_cnt     <= '0;
                r_valid   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_code = CODE_BLANK;
        w_an   = 3'b111;
        unique case (r_dig)
            2'd0: begin
                w_code = r_bcd[3:0];
                w_an   = 3'b110;
            end
            2'd1: begin
                w_code = (r_bcd[11:4] == 8'h00) ? CODE_BLANK : r_bcd[7:4];
                w_an   = 3'b101;
            end
            2'd2: begin
                w_code = (r_bcd[11:8] == 4'h0) ? CODE_BLANK : r_bcd[11:8];
                w_an   = 3'b011;
            end
            default: begin
                w_code = CODE_BLANK;
                w_an   = 3'b111;
            end
        endcase
    end

    seg7_decode u_dec (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    // an and seg share one register stage so they switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= '0;
            r_dig <= 2'd0;
            r_an  <= 3'b111;
            r_seg <= SEG_BLANK;
        end else begin
            if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
                r_ref <= '0;
                r_dig <= (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
            end else begin
                r_ref <= r_ref + 1'b1;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
    assign bus.bcd   = r_bcd;
    assign bus.seg   = r_seg;
    assign bus.an    = r_an;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display with REFRESH_DIV=4.
module tb_alu_result_display;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] scb[$];
    logic        prev_valid = 1'b0;

    alu_result_display_if bus();

    alu_result_display #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected bcd on each rising valid
    always @(negedge clk) begin
        logic [11:0] e;
        if (bus.valid && !prev_valid) begin
            checks++;
            if (scb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got bcd %h want none", bus.bcd);
            end else begin
                e = scb.pop_front();
                if (bus.bcd !== e) begin
                    errors++;
                    $display("FAIL bcd got %h want %h", bus.bcd, e);
                end
            end
        end
        checks++;
        if (bus.busy && bus.valid) begin
            errors++;
            $display("FAIL busy_valid_overlap got 1 want 0");
        end
        prev_valid = bus.valid;
    end

    task automatic convert(input logic [6:0] v, input logic [11:0] exp);
        int nb;
        int k;
        @(negedge clk);
        bus.res  = v;
        bus.load = 1'b1;
        scb.push_back(exp);
        @(negedge clk);
        bus.load = 1'b0;
        nb = 0;
        k  = 0;
        while (!bus.valid && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.busy) nb++;
        end
        chk("busy_cycles", nb, 8);
        chk("latency", k, 9);
    endtask

    task automatic chk_disp(input logic [6:0] sh, input logic [6:0] st,
                            input logic [6:0] so);
        logic [6:0] pat[3];
        logic [2:0] tgt;
        int n;
        pat = '{so, st, sh};
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tgt = ~(3'b001 << d);
            n = 0;
            while (bus.an !== tgt && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("an_digit", bus.an, tgt);
            chk("seg_digit", bus.seg, pat[d]);
        end
    endtask

    initial begin
        logic [2:0] an_exp[13];
        int k;
        an_exp = '{3'b110, 3'b110, 3'b110, 3'b110,
                   3'b101, 3'b101, 3'b101, 3'b101,
                   3'b011, 3'b011, 3'b011, 3'b011,
                   3'b110};
        rst      = 1'b1;
        bus.res  = 7'd99;
        bus.load = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_bcd", bus.bcd, 0);
        chk("rst_an", bus.an, 3'b111);
        chk("rst_seg", bus.seg, 7'b1111111);
        rst      = 1'b0;
        bus.load = 1'b0;

        // Refresh pattern with bcd=0: ones '0', others blank
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("refresh_an", bus.an, an_exp[i]);
            if (i == 0) chk("first_seg", bus.seg, 7'b1000000);
            if (i == 4) chk("blank_tens", bus.seg, 7'b1111111);
            if (i == 8) chk("blank_hund", bus.seg, 7'b1111111);
        end
        chk("load_in_rst_ignored", bus.busy, 0);

        convert(7'd127, 12'h127);
        chk_disp(7'b1111001, 7'b0100100, 7'b1111000);

        convert(7'd5, 12'h005);
        chk_disp(7'b1111111, 7'b1111111, 7'b0010010);

        // Load during conversion must be dropped
        @(negedge clk);
        bus.res  = 7'd100;
        bus.load = 1'b1;
        scb.push_back(12'h100);
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        bus.res  = 7'd42;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        k = 0;
        while (!bus.valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ignored_load_latency", k, 6);
        chk_disp(7'b1111001, 7'b1000000, 7'b1000000);
        repeat (12) @(negedge clk);
        chk("no_queued_load", bus.busy, 0);

        // Reset in the 4th shift cycle aborts the conversion
        @(negedge clk);
        bus.res  = 7'd99;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.valid, 0);
        chk("abort_bcd", bus.bcd, 0);
        convert(7'd64, 12'h064);
        chk_disp(7'b1111111, 7'b0000010, 7'b0011001);

        convert(7'd0, 12'h000);
        chk_disp(7'b1111111, 7'b1111111, 7'b1000000);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", scb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 16, clock cycles each display digit is held.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 Port: res  input  7  ALU result o, unsigned 0..127.
REQ-005 Port: load  input  1  one-cycle strobe; capture res and start conversion.
REQ-006 Port: busy  output  1  high while conversion in progress.
REQ-007 Port: valid  output  1  high while bcd holds the converted value of the last accepted load.
REQ-008 Port: bcd  output  12  {hundreds, tens, ones}, 4 bits each.
REQ-009 Port: seg  output  7  {g,f,e,d,c,b,a}, active-low segments.
REQ-010 Port: an  output  3  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.

Function
REQ-011 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on load; SHIFT->DONE after 7th shift; DONE->IDLE unconditionally.
REQ-012 load accepted only in IDLE; load in SHIFT or DONE ignored, no queuing.
REQ-013 On acceptance: res captured into 7-bit shift register, 12-bit scratch cleared, valid cleared, busy set next cycle.
REQ-014 SHIFT: per cycle, add 3 to each scratch digit >=5, then shift {scratch,shreg} left one bit; exactly 7 cycles.
REQ-015 DONE: bcd <= scratch, valid <= 1, busy <= 0; load accepted at cycle N gives valid=1 and new bcd at cycle N+9 (visible after edge N+9).
REQ-016 busy high cycles N+1..N+8 inclusive; busy and valid never both high.
REQ-017 bcd and valid hold until next accepted load; bcd not cleared on acceptance (display shows old value during conversion).
REQ-018 Refresh counter 0..REFRESH_DIV-1; on wrap digit index advances 0->1->2->0.
REQ-019 an registered: only the selected digit bit low.
REQ-020 seg registered from selected bcd digit through BCD-to-7-segment decode; digits 0-9 standard patterns, codes 10-15 blank (7'b1111111).
REQ-021 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens both 0; ones always shown.
REQ-022 an and seg change together in the same cycle; no ghost cycle with new an and old seg.

Reset
REQ-023 rst high at an edge: state IDLE, busy=0, valid=0, bcd=12'h000, shift/scratch cleared, refresh counter 0, digit index 0, an=3'b111, seg=7'b1111111.
REQ-024 First edge after rst release: an=3'b110, seg=7'b1000000 ('0').
REQ-025 rst mid-conversion aborts it; load during rst ignored.

Structure
REQ-026 Package calc_pkg holds FSM state encoding, digit/result widths (RES_W=7, BCD_W=12) and 7-segment pattern constants for 0-9 and blank.
REQ-027 Sub-module seg7_decode: combinational 4-bit BCD in, 7-bit active-low seg out, blank for 10-15.

Verification
REQ-028 res=127, load 1 cycle -> busy 8 cycles, then valid=1, bcd=12'h127; displays 1,2,7 on an 011/101/110.
REQ-029 res=5 -> bcd=12'h005; seg=7'b1111111 when an=3'b011 or 3'b101, seg=7'b0010010 when an=3'b110.
REQ-030 res=100 then load res=42 at cycle 3 of busy -> ignored; bcd=12'h100 with tens '0' shown (7'b1000000).
REQ-031 rst high at 4th SHIFT cycle -> next cycle busy=0, valid=0, bcd=0; then res=64 load -> bcd=12'h064 after 9 cycles.
REQ-032 REFRESH_DIV=4 -> an sequence 110,101,011 each held exactly 4 cycles, wraps to 110.
REQ-033 res=0 -> bcd=12'h000; only ones digit lit with '0', hundreds and tens blank.
